uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds configurable data width, stop-bit count, optional parity, an exact internal baud divisor and a small transmit FIFO, so that back-to-back frames go out with no idle gap. It sits between a host write port and the serial TX pin, alongside the existing receiver.

---
 rtl/uart_tx_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO and exact baud divisor.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_fifo #(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int PARITY_ODD      = 0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DATA_BITS-1:0]          TxDataInput,
    input  logic                          TxEnable,
    output logic                          TxReady,
    output logic                          TxWire,
    output logic                          TxBusy,
    output logic [$clog2(FIFO_DEPTH):0]   TxFifoCount,
    output logic                          TxOverflow
);

    localparam int DIVISOR  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW       = $clog2(DIVISOR);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BW       = $clog2(DATA_BITS);
    localparam int RELOAD_I = DIVISOR - 1;
    localparam int LASTB_I  = DATA_BITS - 1;

    localparam logic [CW-1:0] BAUD_RELOAD = RELOAD_I[CW-1:0];
    localparam logic [BW-1:0] LAST_BIT    = LASTB_I[BW-1:0];
    localparam logic [AW:0]   FULL_COUNT  = FIFO_DEPTH[AW:0];
    localparam logic          LAST_STOP   = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter set");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_baud;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_ovf;
`ifdef UART_TX_PARITY_EN
    localparam logic ODD_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    logic                 r_parity;
`endif

    logic                 w_ready;
    logic                 w_write;
    logic                 w_tick;
    logic                 w_has_data;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign w_ready    = (r_count != FULL_COUNT);
    assign w_write    = TxEnable & w_ready;
    assign w_tick     = (r_baud == {CW{1'b0}});
    assign w_has_data = (r_count != {(AW+1){1'b0}});
    assign w_head     = r_mem[r_rd_ptr];

    // A pop starts a new frame: from IDLE at once, or at the end of the last stop bit.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_has_data;
            S_STOP:  w_pop = w_tick & (r_stop_cnt == LAST_STOP) & w_has_data;
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO storage, pointers and occupancy; a full FIFO rejects the write even if popping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DATA_BITS{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= TxEnable & ~w_ready;
            if (w_write) begin
                r_mem[r_wr_ptr] <= TxDataInput;
                r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Bit timer: restarts on every pop so each bit lasts exactly DIVISOR cycles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_baud <= BAUD_RELOAD;
        end else if (w_pop || w_tick) begin
            r_baud <= BAUD_RELOAD;
        end else begin
            r_baud <= r_baud - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Frame sequencer driving the registered serial line.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_shift    <= {DATA_BITS{1'b0}};
            r_bit_cnt  <= {BW{1'b0}};
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity <= (^w_head) ^ ODD_SENSE;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= {BW{1'b0}};
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_STOP;
`endif
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt != LAST_STOP) begin
                            r_stop_cnt <= 1'b1;
                        end else if (w_pop) begin
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TxReady     = w_ready;
    assign TxWire      = r_tx;
    assign TxBusy      = (r_state != S_IDLE) | w_has_data;
    assign TxFifoCount = r_count;
    assign TxOverflow  = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int DB = 7, SB = 2, PODD = 1, PB = 1;
    localparam int LIT_LEN  = 44;
    localparam int LIT_BUSY = 221;
    localparam logic [10:0] SINGLE_EXP  = 11'b11100000110;
    localparam logic [6:0]  SINGLE_DATA = 7'h03;
`else
    localparam int DB = 8, SB = 1, PODD = 0, PB = 0;
    localparam int LIT_LEN  = 40;
    localparam int LIT_BUSY = 201;
    localparam logic [9:0]  SINGLE_EXP  = 10'b1010101010;
    localparam logic [7:0]  SINGLE_DATA = 8'h55;
`endif
    localparam int CF = 40, BR = 10, DEPTH = 4;
    localparam int DIV = CF / BR;
    localparam int FB  = 1 + DB + PB + SB;
    localparam int LEN = DIV * FB;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [DB-1:0] TxDataInput = '0;
    logic          TxEnable = 1'b0;
    logic          TxReady, TxWire, TxBusy, TxOverflow;
    logic [2:0]    TxFifoCount;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(
        .CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(DB),
        .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
    ) dut (
        .Clk(Clk), .Reset(Reset), .TxDataInput(TxDataInput), .TxEnable(TxEnable),
        .TxReady(TxReady), .TxWire(TxWire), .TxBusy(TxBusy),
        .TxFifoCount(TxFifoCount), .TxOverflow(TxOverflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected serial frame for a word: start, data LSB first, optional parity, stop(s).
    function automatic logic [FB-1:0] make_frame(input logic [DB-1:0] d);
        logic [FB-1:0] f;
        f = {FB{1'b1}};
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[1+DB] = (^d) ^ (PODD != 0);
`endif
        return f;
    endfunction

    // Model: a queue of words and the frame currently on the line with its start edge.
    logic [DB-1:0] mq[$];
    logic [FB-1:0] m_frame = '1;
    int  m_t0 = 0, m_edge = 0;
    bit  m_active = 1'b0;
    bit  m_wire = 1'b1, m_ovf = 1'b0;
    bit  m_rdy, m_pop, m_done;

    initial begin
        forever begin
            @(posedge Clk or negedge Reset);
            if (!Reset) begin
                mq.delete();
                m_active = 1'b0;
                m_wire   = 1'b1;
                m_ovf    = 1'b0;
                m_edge   = 0;
            end else begin
                m_rdy  = (mq.size() != DEPTH);
                m_done = m_active && (m_edge - m_t0 == LEN);
                m_pop  = (!m_active || m_done) && (mq.size() != 0);
                m_ovf  = TxEnable && !m_rdy;
                if (m_pop) begin
                    m_frame  = make_frame(mq.pop_front());
                    m_t0     = m_edge;
                    m_active = 1'b1;
                end else if (m_done) begin
                    m_active = 1'b0;
                end
                if (TxEnable && m_rdy) mq.push_back(TxDataInput);
                m_wire = m_active ? m_frame[(m_edge - m_t0) / DIV] : 1'b1;
                m_edge++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge Clk);
            check("wire",  int'(TxWire),      int'(m_wire));
            check("count", int'(TxFifoCount), mq.size());
            check("ready", int'(TxReady),     int'(mq.size() != DEPTH));
            check("busy",  int'(TxBusy),      int'(m_active || mq.size() != 0));
            check("ovf",   int'(TxOverflow),  int'(m_ovf));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic put(input logic [DB-1:0] d);
        @(negedge Clk);
        TxEnable    = 1'b1;
        TxDataInput = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic release_en();
        @(negedge Clk);
        TxEnable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (TxBusy && n < 8 * LEN) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check(name, int'(TxBusy), 0);
        repeat (3) @(negedge Clk);
    endtask

    logic [FB-1:0] got;
    int busy_cycles, ovf_cnt, low_cnt, busy_hi, n;

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_wire",  int'(TxWire), 1);
        check("rst_ready", int'(TxReady), 1);
        check("rst_busy",  int'(TxBusy), 0);
        check("rst_count", int'(TxFifoCount), 0);
        check("rst_ovf",   int'(TxOverflow), 0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);

        // Single word: bits sampled mid-bit.
        put(SINGLE_DATA);
        check("single_count", int'(TxFifoCount), 1);
        check("single_pre",   int'(TxWire), 1);
        release_en();
        @(posedge Clk);
        #1;
        check("single_start", int'(TxWire), 0);
        for (int j = 0; j < FB; j++) begin
            repeat ((j == 0) ? 2 : 4) @(posedge Clk);
            #1;
            got[j] = TxWire;
        end
        check("single_frame", int'(got), int'(SINGLE_EXP));
        @(posedge Clk);
        #1;
        check("single_busy_end", int'(TxBusy), 1);
        @(posedge Clk);
        #1;
        check("single_busy_off", int'(TxBusy), 0);
        wait_idle("single_idle");

        // Back-to-back words.
        put(DB'(8'hA5));
        check("b2b_cnt1", int'(TxFifoCount), 1);
        put(DB'(8'h3C));
        check("b2b_cnt2", int'(TxFifoCount), 1);
        put(DB'(8'hFF));
        check("b2b_cnt3", int'(TxFifoCount), 2);
        release_en();
        repeat (LIT_LEN - 2) @(posedge Clk);
        #1;
        check("b2b_stop", int'(TxWire), 1);
        @(posedge Clk);
        #1;
        check("b2b_next_start", int'(TxWire), 0);
        wait_idle("b2b_idle");

        // Overflow: six consecutive writes into a depth-4 FIFO.
        busy_cycles = 0;
        ovf_cnt     = 0;
        for (int i = 0; i < 6; i++) begin
            put(DB'(i + 1));
            busy_cycles += int'(TxBusy);
            ovf_cnt     += int'(TxOverflow);
        end
        check("ovf_pulse", int'(TxOverflow), 1);
        check("ovf_ready", int'(TxReady), 0);
        check("ovf_count", int'(TxFifoCount), 4);
        release_en();
        n = 0;
        while (n < 8 * LEN) begin
            @(posedge Clk);
            #1;
            if (!TxBusy) break;
            busy_cycles++;
            ovf_cnt += int'(TxOverflow);
            n++;
        end
        check("ovf_busy_len", busy_cycles, LIT_BUSY);
        check("ovf_once", ovf_cnt, 1);
        wait_idle("ovf_idle");

        // Reset during data bit 3 with two words queued.
        put(DB'(8'h11));
        put(DB'(8'h22));
        put(DB'(8'h44));
        release_en();
        repeat (16) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("rstmid_wire",  int'(TxWire), 1);
        check("rstmid_count", int'(TxFifoCount), 0);
        check("rstmid_busy",  int'(TxBusy), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        low_cnt = 0;
        busy_hi = 0;
        for (int i = 0; i < 3 * LEN; i++) begin
            @(negedge Clk);
            if (!TxWire) low_cnt++;
            busy_hi += int'(TxBusy);
        end
        check("rstmid_no_frame", low_cnt, 0);
        check("rstmid_no_busy", busy_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
